// File: rtl/hazard_bubble_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the ID/EX hazard bubble controller:
//   - FSM state enumeration
//   - default control-bundle and register-address widths
//   - bit offsets of the fields inside the ID/EX control bundle
// -----------------------------------------------------------------------------
package hazard_pkg;

    // Controller states: normal flow, load-use stall, branch flush
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hazard_state_t;

    // Default widths
    localparam int CTRL_W_DEF = 9;
    localparam int REG_AW_DEF = 5;

    // ID/EX control bundle layout (LSB first):
    // regDest[0], aluOp[2:1], aluSrc[3], mem[6:4], wb[8:7]
    localparam int REGDEST_OFF = 0;
    localparam int REGDEST_W   = 1;
    localparam int ALUOP_OFF   = 1;
    localparam int ALUOP_W     = 2;
    localparam int ALUSRC_OFF  = 3;
    localparam int ALUSRC_W    = 1;
    localparam int MEM_OFF     = 4;
    localparam int MEM_W       = 3;
    localparam int WB_OFF      = 7;
    localparam int WB_W        = 2;

endpackage

// File: rtl/hazard_bubble_ctrl_mux.sv
// -----------------------------------------------------------------------------
// hazard_bubble_mux
// Combinational zero-or-pass selection of the ID/EX control bundle.
// A bubble is a bundle of all zeros, i.e. an instruction with no side effects.
// Ports:
//   bubble   in  1       1 = emit all-zero bundle, 0 = pass ctrl_in
//   ctrl_in  in  CTRL_W  decoded control bundle
//   ctrl_sel out CTRL_W  selected bundle (next value of the ID/EX register)
// -----------------------------------------------------------------------------
module hazard_bubble_mux #(
    parameter int CTRL_W = 9
) (
    input  logic              bubble,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic [CTRL_W-1:0] ctrl_sel
);

    // Select either the incoming bundle or an all-zero bubble
    always_comb begin
        ctrl_sel = '0;
        if (bubble) begin
            ctrl_sel = '0;
        end else begin
            ctrl_sel = ctrl_in;
        end
    end

endmodule

// File: rtl/hazard_bubble_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_bubble_ctrl
// Pipeline hazard controller: inserts bubbles into the ID/EX control register
// on load-use hazards (stalling PC and IF/ID) and on taken branches (flushing
// IF/ID). Branch flush always wins over a stall.
//
// Optional feature macro: HAZARD_STATS_EN adds a 16-bit saturating
// bubble-cycle counter on output stall_count.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   synchronous active-low reset
//   ctrl_in       in   CTRL_W decoded control bundle from ID
//   id_rs, id_rt  in   REG_AW source registers of the instruction in ID
//   ex_mem_read   in   instruction in EX is a load
//   ex_rt         in   REG_AW load destination in EX
//   branch_taken  in   branch resolved taken this cycle
//   ctrl_out      out  registered ID/EX control bundle
//   pc_write      out  PC write enable
//   ifid_write    out  IF/ID write enable
//   ifid_flush    out  clear IF/ID this cycle
//   busy          out  controller is in a multi-cycle stall or flush
//   stall_count   out  (HAZARD_STATS_EN only) bubble cycles, saturating
// -----------------------------------------------------------------------------
module hazard_bubble_ctrl
    import hazard_pkg::*;
#(
    parameter int CTRL_W       = CTRL_W_DEF,
    parameter int REG_AW       = REG_AW_DEF,
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              branch_taken,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    localparam logic [2:0] STALL_RELOAD = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    hazard_state_t     state_r;
    hazard_state_t     state_next_s;
    logic [2:0]        cnt_r;
    logic [2:0]        cnt_next_s;
    logic              hazard_s;
    logic              bubble_s;
    logic              pc_write_s;
    logic              ifid_write_s;
    logic              ifid_flush_s;
    logic [CTRL_W-1:0] ctrl_sel_s;

    // Load-use hazard detection; register zero never carries a dependency
    assign hazard_s = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    // Next-state, counter and per-cycle enable decode
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        bubble_s     = 1'b0;
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
        ifid_flush_s = 1'b0;
        if (!reset) begin
            // Hold the front end and clear IF/ID while in reset
            state_next_s = ST_IDLE;
            cnt_next_s   = 3'd0;
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            ifid_flush_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (branch_taken) begin
                        bubble_s     = 1'b1;
                        ifid_flush_s = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_next_s = ST_FLUSH;
                            cnt_next_s   = FLUSH_RELOAD;
                        end else begin
                            state_next_s = ST_IDLE;
                            cnt_next_s   = 3'd0;
                        end
                    end else if (hazard_s) begin
                        bubble_s     = 1'b1;
                        pc_write_s   = 1'b0;
                        ifid_write_s = 1'b0;
                        if (STALL_CYCLES > 1) begin
                            state_next_s = ST_STALL;
                            cnt_next_s   = STALL_RELOAD;
                        end else begin
                            state_next_s = ST_IDLE;
                            cnt_next_s   = 3'd0;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = 3'd0;
                    end
                end
                ST_STALL: begin
                    bubble_s = 1'b1;
                    if (branch_taken) begin
                        // A taken branch makes the stalled instruction dead
                        ifid_flush_s = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_next_s = ST_FLUSH;
                            cnt_next_s   = FLUSH_RELOAD;
                        end else begin
                            state_next_s = ST_IDLE;
                            cnt_next_s   = 3'd0;
                        end
                    end else begin
                        pc_write_s   = 1'b0;
                        ifid_write_s = 1'b0;
                        if (cnt_r == 3'd1) begin
                            state_next_s = ST_IDLE;
                            cnt_next_s   = 3'd0;
                        end else begin
                            cnt_next_s = cnt_r - 3'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    bubble_s     = 1'b1;
                    ifid_flush_s = 1'b1;
                    if (cnt_r == 3'd1) begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = 3'd0;
                    end else begin
                        cnt_next_s = cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 3'd0;
                end
            endcase
        end
    end

    hazard_bubble_mux #(
        .CTRL_W (CTRL_W)
    ) u_mux (
        .bubble   (bubble_s),
        .ctrl_in  (ctrl_in),
        .ctrl_sel (ctrl_sel_s)
    );

    // FSM state, bubble counter and ID/EX control register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 3'd0;
            ctrl_out <= '0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            ctrl_out <= ctrl_sel_s;
        end
    end

    assign pc_write   = pc_write_s;
    assign ifid_write = ifid_write_s;
    assign ifid_flush = ifid_flush_s;
    assign busy       = (state_r != ST_IDLE);

`ifdef HAZARD_STATS_EN
    // Saturating count of bubble cycles
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_count <= 16'd0;
        end else if (bubble_s && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end else begin
            stall_count <= stall_count;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_bubble_ctrl
// Two controllers share one input stream: instance 0 with STALL=1/FLUSH=1,
// instance 1 with STALL=3/FLUSH=2. Each is compared every cycle against a
// model that tracks "bubbles still owed" as plain integers.
// -----------------------------------------------------------------------------
module tb_hazard_bubble_ctrl;

    localparam int N = 2;
    localparam int S_CYC [N] = '{1, 3};
    localparam int F_CYC [N] = '{1, 2};

    logic       clock = 1'b0;
    logic       reset;
    logic [8:0] ctrl_in;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_mem_read, branch_taken;

    logic [8:0] ctrl_out   [N];
    logic       pc_write   [N];
    logic       ifid_write [N];
    logic       ifid_flush [N];
    logic       busy       [N];
    logic [15:0] stall_count [N];

    int checks   = 0;
    int failures = 0;

    // Model state
    int         stall_left [N];
    int         flush_left [N];
    logic [8:0] exp_ctrl   [N];
    int         exp_count  [N];

    always #5 clock = ~clock;

    hazard_bubble_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(1)) dut0 (
        .clock(clock), .reset(reset), .ctrl_in(ctrl_in),
        .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .branch_taken(branch_taken),
        .ctrl_out(ctrl_out[0]), .pc_write(pc_write[0]),
        .ifid_write(ifid_write[0]), .ifid_flush(ifid_flush[0]),
        .busy(busy[0])
`ifdef HAZARD_STATS_EN
        , .stall_count(stall_count[0])
`endif
    );

    hazard_bubble_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut1 (
        .clock(clock), .reset(reset), .ctrl_in(ctrl_in),
        .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .branch_taken(branch_taken),
        .ctrl_out(ctrl_out[1]), .pc_write(pc_write[1]),
        .ifid_write(ifid_write[1]), .ifid_flush(ifid_flush[1]),
        .busy(busy[1])
`ifdef HAZARD_STATS_EN
        , .stall_count(stall_count[1])
`endif
    );

`ifndef HAZARD_STATS_EN
    assign stall_count[0] = 16'd0;
    assign stall_count[1] = 16'd0;
`endif

    task automatic check(input string tag, input int inst, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check this-cycle enables, then registered state
    task automatic cycle(input logic rst, input logic br, input logic mr,
                         input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [8:0] cin);
        @(negedge clock);
        reset = rst; branch_taken = br; ex_mem_read = mr;
        ex_rt = ert; id_rs = rs; id_rt = rt; ctrl_in = cin;
        #1;
        for (int i = 0; i < N; i++) begin
            bit hz, bubble, e_pcw, e_ifw, e_fl, e_busy;
            hz     = mr && (ert != 5'd0) && ((ert == rs) || (ert == rt));
            e_busy = (stall_left[i] > 0) || (flush_left[i] > 0);
            bubble = 1'b0; e_pcw = 1'b1; e_ifw = 1'b1; e_fl = 1'b0;
            if (!rst) begin
                e_pcw = 1'b0; e_ifw = 1'b0; e_fl = 1'b1;
                stall_left[i] = 0; flush_left[i] = 0;
            end else if (flush_left[i] > 0) begin
                bubble = 1'b1; e_fl = 1'b1;
                flush_left[i]--;
            end else if (br) begin
                // Taken branch flushes, and cancels any remaining stall
                bubble = 1'b1; e_fl = 1'b1;
                stall_left[i] = 0;
                flush_left[i] = F_CYC[i] - 1;
            end else if (stall_left[i] > 0) begin
                bubble = 1'b1; e_pcw = 1'b0; e_ifw = 1'b0;
                stall_left[i]--;
            end else if (hz) begin
                bubble = 1'b1; e_pcw = 1'b0; e_ifw = 1'b0;
                stall_left[i] = S_CYC[i] - 1;
            end
            check("pc_write",   i, 32'(pc_write[i]),   32'(e_pcw));
            check("ifid_write", i, 32'(ifid_write[i]), 32'(e_ifw));
            check("ifid_flush", i, 32'(ifid_flush[i]), 32'(e_fl));
            check("busy",       i, 32'(busy[i]),       32'(e_busy));
            if (!rst) begin
                exp_ctrl[i]  = 9'd0;
                exp_count[i] = 0;
            end else begin
                exp_ctrl[i] = bubble ? 9'd0 : cin;
                if (bubble && exp_count[i] < 65535) exp_count[i]++;
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            check("ctrl_out", i, 32'(ctrl_out[i]), 32'(exp_ctrl[i]));
            check("busy_post", i, 32'(busy[i]),
                  32'((stall_left[i] > 0) || (flush_left[i] > 0)));
`ifdef HAZARD_STATS_EN
            check("stall_count", i, 32'(stall_count[i]), 32'(exp_count[i]));
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 9'(k * 37 + 5));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            stall_left[i] = 0; flush_left[i] = 0; exp_ctrl[i] = 9'd0; exp_count[i] = 0;
        end
        reset = 1'b0; branch_taken = 1'b0; ex_mem_read = 1'b0;
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; ctrl_in = 9'd0;

        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 9'h1FF);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 9'h0AA);
        idle(2);

        // Load-use on rs, then on rt
        cycle(1'b1, 1'b0, 1'b1, 5'd8, 5'd8, 5'd3, 9'h155);
        idle(4);
        cycle(1'b1, 1'b0, 1'b1, 5'd9, 5'd2, 5'd9, 9'h0F0);
        idle(4);

        // Register zero never stalls
        cycle(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 9'h133);
        cycle(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 9'h0CC);

        // Load without dependency
        cycle(1'b1, 1'b0, 1'b1, 5'd7, 5'd6, 5'd5, 9'h1E1);

        // Branch and hazard together: flush wins
        cycle(1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 5'd8, 9'h1AB);
        idle(3);

        // Hazard inputs ignored during stall; branch aborts a stall
        cycle(1'b1, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 9'h011);
        cycle(1'b1, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 9'h022);
        cycle(1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 9'h033);
        idle(3);

        // Reset in the 2nd cycle of a 3-cycle stall
        cycle(1'b1, 1'b0, 1'b1, 5'd12, 5'd12, 5'd1, 9'h0FE);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 9'h1FF);
        idle(2);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 39) != 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  9'($urandom));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_bubble_ctrl.md
HAZARD_BUBBLE_CTRL -- requirements
Module: hazard_bubble_ctrl

Interface
REQ-001 Parameter CTRL_W, default 9, SHALL set the width of the ID/EX control bundle (regDest 1, aluOp 2, aluSrc 1, mem 3, wb 2).
REQ-002 Parameter REG_AW, default 5, SHALL set the register-address width.
REQ-003 Parameter STALL_CYCLES, default 1, range 1..7, SHALL set the bubbles inserted per load-use hazard.
REQ-004 Parameter FLUSH_CYCLES, default 1, range 1..7, SHALL set the bubbles inserted per taken branch.
REQ-005 Ports SHALL be:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- ctrl_in  in  CTRL_W  decoded control bundle from the ID stage.
- id_rs, id_rt  in  REG_AW  source registers of the instruction in ID.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rt  in  REG_AW  load destination in EX.
- branch_taken  in  1  branch resolved taken this cycle.
- ctrl_out  out  CTRL_W  registered ID/EX control bundle.
- pc_write, ifid_write  out  1  PC and IF/ID write enables.
- ifid_flush  out  1  clear IF/ID this cycle.
- busy  out  1  FSM not in IDLE.

Function
REQ-006 A hazard SHALL be defined as ex_mem_read=1 and ex_rt!=0 and (ex_rt==id_rs or ex_rt==id_rt).
REQ-007 The FSM SHALL have exactly 3 states: IDLE, STALL, FLUSH, plus a 3-bit remaining-bubble counter cnt.
REQ-008 In a cycle with no bubble, ctrl_out SHALL load ctrl_in at the next edge (latency 1), and pc_write=ifid_write=1, ifid_flush=0.
REQ-009 In a bubble cycle, ctrl_out SHALL load all-zero at the next edge.
REQ-010 IDLE with branch_taken=1 SHALL be a bubble cycle with ifid_flush=1; if FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; else stay in IDLE.
REQ-011 IDLE with hazard and branch_taken=0 SHALL be a bubble cycle with pc_write=ifid_write=0; if STALL_CYCLES>1, go to STALL with cnt=STALL_CYCLES-1; else stay in IDLE.
REQ-012 branch_taken and hazard in the same cycle SHALL resolve as a branch: flush has priority.
REQ-013 STALL SHALL be a bubble cycle with pc_write=ifid_write=0 and SHALL decrement cnt; when cnt==1, go to IDLE.
REQ-014 FLUSH SHALL be a bubble cycle with ifid_flush=1 and pc_write=1 and SHALL decrement cnt; when cnt==1, go to IDLE.
REQ-015 branch_taken=1 during STALL SHALL abort the stall and go to FLUSH with cnt=FLUSH_CYCLES-1, or to IDLE if FLUSH_CYCLES==1; that cycle SHALL be a flush bubble.
REQ-016 Hazard inputs SHALL be ignored while in STALL or FLUSH.
REQ-017 busy SHALL be 1 exactly when state!=IDLE.

Reset
REQ-018 reset=0 at an edge SHALL set state=IDLE, cnt=0, ctrl_out=0, regardless of the current state, mid-stall included.
REQ-019 While reset=0, pc_write=ifid_write=0 and ifid_flush=1.

Configuration
REQ-020 With macro HAZARD_STATS_EN defined, the block SHALL add output stall_count (16 bits), incremented once per bubble cycle, saturating at 0xFFFF and cleared by reset.
REQ-021 Without HAZARD_STATS_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-022 Package hazard_pkg SHALL hold the state enumeration, default CTRL_W/REG_AW constants and the control-bundle field offsets.
REQ-023 The zero-or-pass bundle selection SHALL be a sub-module, hazard_bubble_mux (parametrised on CTRL_W, combinational).

Verification
REQ-024 Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, STALL_CYCLES=1 -> pc_write=0 for 1 cycle; ctrl_out=0 after the next edge, then ctrl_in.
REQ-025 Register zero: ex_rt=0, id_rs=0, ex_mem_read=1 -> no stall; ctrl_out follows ctrl_in with latency 1.
REQ-026 STALL_CYCLES=3 hazard -> exactly 3 consecutive cycles of pc_write=0 and 3 zero bundles; busy=1 for 2 cycles.
REQ-027 Simultaneous branch_taken and hazard, FLUSH_CYCLES=2 -> ifid_flush=1 for 2 cycles, pc_write stays 1, no stall.
REQ-028 Reset asserted in the 2nd cycle of a 3-cycle stall -> next cycle state=IDLE, ctrl_out=0, busy=0.
REQ-029 With HAZARD_STATS_EN, 4 hazards at STALL_CYCLES=2 -> stall_count=8.
